// File: rtl/ysyx_25060170_wbu.sv
// ============================================================================
// ysyx_25060170_wbu : writeback unit, one-entry result stage with load extension
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ysyx_25060170_wbu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pc,
  input  logic [4:0]   in_rd,
  input  logic         in_rd_wen,
  input  logic [1:0]   in_sel,
  input  logic [W-1:0] in_alu,
  input  logic [W-1:0] in_ld_data,
  input  logic [1:0]   in_ld_addr_lo,
  input  logic [2:0]   in_ld_funct3,
  input  logic [W-1:0] in_csr_rdata,
  input  logic         gpr_ready,
  output logic [W-1:0] wdata,
  output logic [4:0]   waddr,
  output logic         wen,
  output logic         commit_valid,
  output logic [W-1:0] commit_pc,
  output logic [W-1:0] retire_cnt
);

  localparam logic [1:0] C_SEL_ALU  = 2'b00;
  localparam logic [1:0] C_SEL_LOAD = 2'b01;
  localparam logic [1:0] C_SEL_PC4  = 2'b10;
  localparam logic [W-1:0] C_PC_STEP = W'(4);

  logic         r_wb_valid;
  logic [W-1:0] r_pc;
  logic [4:0]   r_rd;
  logic         r_rd_wen;
  logic [W-1:0] r_result;
  logic [W-1:0] r_retire_cnt;

  logic         w_accept;
  logic         w_retire;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [W-1:0] w_load;
  logic [W-1:0] w_result;

  assign in_ready = !r_wb_valid || gpr_ready;
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_wb_valid && gpr_ready;

  // Lane select: halves use only addr_lo[1], bytes use both address bits
  assign w_byte = in_ld_data[{in_ld_addr_lo, 3'b000} +: 8];
  assign w_half = in_ld_data[{in_ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_load = in_ld_data;
    case (in_ld_funct3)
      3'b000:  w_load = {{(W-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(W-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(W-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(W-16){1'b0}}, w_half};
      default: w_load = in_ld_data;
    endcase
  end

  always_comb begin
    w_result = in_csr_rdata;
    case (in_sel)
      C_SEL_ALU:  w_result = in_alu;
      C_SEL_LOAD: w_result = w_load;
      C_SEL_PC4:  w_result = in_pc + C_PC_STEP;
      default:    w_result = in_csr_rdata;
    endcase
  end

  // A same-cycle retire and accept reloads the entry without a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid   <= 1'b0;
      r_pc         <= '0;
      r_rd         <= '0;
      r_rd_wen     <= 1'b0;
      r_result     <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_wb_valid <= 1'b1;
        r_pc       <= in_pc;
        r_rd       <= in_rd;
        r_rd_wen   <= in_rd_wen;
        r_result   <= w_result;
      end else if (w_retire) begin
        r_wb_valid <= 1'b0;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + W'(1);
      end
    end
  end

  assign wen          = w_retire && r_rd_wen && (r_rd != 5'd0);
  assign waddr        = r_rd;
  assign wdata        = r_result;
  assign commit_valid = w_retire;
  assign commit_pc    = r_pc;
  assign retire_cnt   = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060170_wbu.sv
// ============================================================================
// tb_ysyx_25060170_wbu : directed self-checking bench for the writeback unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25060170_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [1:0]  in_sel;
  logic [31:0] in_alu;
  logic [31:0] in_ld_data;
  logic [1:0]  in_ld_addr_lo;
  logic [2:0]  in_ld_funct3;
  logic [31:0] in_csr_rdata;
  logic        gpr_ready;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wen;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] retire_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_25060170_wbu #(.W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_sel(in_sel),
    .in_alu(in_alu), .in_ld_data(in_ld_data), .in_ld_addr_lo(in_ld_addr_lo),
    .in_ld_funct3(in_ld_funct3), .in_csr_rdata(in_csr_rdata),
    .gpr_ready(gpr_ready), .wdata(wdata), .waddr(waddr), .wen(wen),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu);
    in_valid = 1'b1;
    in_sel   = sel;
    in_rd    = rd;
    in_alu   = alu;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_rd = 5'd0; in_rd_wen = 1'b1;
    in_sel = 2'b00; in_alu = 32'h0; in_ld_data = 32'h80FF7F01; in_ld_addr_lo = 2'd0;
    in_ld_funct3 = 3'b010; in_csr_rdata = 32'h0; gpr_ready = 1'b1;
    tick(); tick();
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_commit", {31'd0, commit_valid}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;

    // ALU path
    in_pc = 32'h0000_0100;
    issue(2'b00, 5'd5, 32'h12345678);
    tick();
    in_valid = 1'b0;
    chk("alu_wen", {31'd0, wen}, 32'd1);
    chk("alu_waddr", {27'd0, waddr}, 32'd5);
    chk("alu_wdata", wdata, 32'h12345678);
    chk("alu_commit", {31'd0, commit_valid}, 32'd1);
    chk("alu_commit_pc", commit_pc, 32'h0000_0100);
    tick();
    chk("alu_cnt", retire_cnt, 32'd1);
    chk("alu_idle_commit", {31'd0, commit_valid}, 32'd0);

    // Loads from 0x80FF7F01
    in_ld_funct3 = 3'b000; in_ld_addr_lo = 2'd2; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("lb_a2", wdata, 32'hFFFFFFFF);
    in_ld_funct3 = 3'b100; in_ld_addr_lo = 2'd3; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("lbu_a3", wdata, 32'h00000080);
    in_ld_funct3 = 3'b001; in_ld_addr_lo = 2'd0; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("lh_a0", wdata, 32'h00007F01);
    in_ld_funct3 = 3'b101; in_ld_addr_lo = 2'd2; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("lhu_a2", wdata, 32'h000080FF);
    in_ld_funct3 = 3'b001; in_ld_addr_lo = 2'd3; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("lh_a3", wdata, 32'hFFFF80FF);
    in_ld_funct3 = 3'b000; in_ld_addr_lo = 2'd1; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("lb_a1", wdata, 32'h0000007F);
    in_ld_funct3 = 3'b110; in_ld_addr_lo = 2'd1; issue(2'b01, 5'd6, 32'h0);
    tick(); in_valid = 1'b0;
    chk("ld_other", wdata, 32'h80FF7F01);

    // CSR path
    in_csr_rdata = 32'hCAFEBABE; issue(2'b11, 5'd7, 32'h0);
    tick(); in_valid = 1'b0;
    chk("csr_wdata", wdata, 32'hCAFEBABE);
    chk("csr_waddr", {27'd0, waddr}, 32'd7);
    tick();
    chk("cnt_after_csr", retire_cnt, 32'd9);

    // Backpressure: entry held while the register file stalls
    gpr_ready = 1'b0; in_pc = 32'h0000_0200;
    issue(2'b00, 5'd9, 32'hA5A5A5A5);
    tick();
    in_alu = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_wen", {31'd0, wen}, 32'd0);
      chk("bp_commit", {31'd0, commit_valid}, 32'd0);
      chk("bp_wdata", wdata, 32'hA5A5A5A5);
      chk("bp_waddr", {27'd0, waddr}, 32'd9);
      tick();
    end
    in_valid = 1'b0; gpr_ready = 1'b1;
    #1;
    chk("bp_rel_wen", {31'd0, wen}, 32'd1);
    chk("bp_rel_commit", {31'd0, commit_valid}, 32'd1);
    chk("bp_rel_wdata", wdata, 32'hA5A5A5A5);
    chk("bp_rel_pc", commit_pc, 32'h0000_0200);
    tick();
    chk("bp_once_wen", {31'd0, wen}, 32'd0);
    chk("bp_cnt", retire_cnt, 32'd10);

    // Back-to-back stream with no bubbles
    for (int k = 0; k < 4; k++) begin
      issue(2'b00, 5'(10 + k), 32'(k + 1));
      tick();
      chk("b2b_wen", {31'd0, wen}, 32'd1);
      chk("b2b_wdata", wdata, 32'(k + 1));
      chk("b2b_waddr", {27'd0, waddr}, 32'(10 + k));
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain_wen", {31'd0, wen}, 32'd0);
    chk("b2b_cnt", retire_cnt, 32'd14);

    // JAL to x0 and x1 with PC+4 wrapping
    in_pc = 32'hFFFFFFFC;
    issue(2'b10, 5'd0, 32'h0);
    tick(); in_valid = 1'b0;
    chk("x0_wen", {31'd0, wen}, 32'd0);
    chk("x0_commit", {31'd0, commit_valid}, 32'd1);
    chk("x0_commit_pc", commit_pc, 32'hFFFFFFFC);
    issue(2'b10, 5'd1, 32'h0);
    tick(); in_valid = 1'b0;
    chk("jal_wen", {31'd0, wen}, 32'd1);
    chk("jal_wdata", wdata, 32'h00000000);
    chk("jal_waddr", {27'd0, waddr}, 32'd1);
    in_rd_wen = 1'b0;
    issue(2'b00, 5'd3, 32'h55);
    tick(); in_valid = 1'b0;
    chk("nowen_wen", {31'd0, wen}, 32'd0);
    chk("nowen_commit", {31'd0, commit_valid}, 32'd1);
    tick();
    chk("cnt_after_x0", retire_cnt, 32'd17);
    in_rd_wen = 1'b1;

    // Reset while an entry is stalled
    gpr_ready = 1'b0;
    issue(2'b00, 5'd4, 32'h11);
    tick(); in_valid = 1'b0;
    chk("mid_stall_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wen", {31'd0, wen}, 32'd0);
    chk("mid_rst_cnt", retire_cnt, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_waddr", {27'd0, waddr}, 32'd0);
    gpr_ready = 1'b1;
    #1 rst = 1'b1;
    tick();
    chk("post_rst_wen", {31'd0, wen}, 32'd0);
    chk("post_rst_commit", {31'd0, commit_valid}, 32'd0);
    chk("post_rst_cnt", retire_cnt, 32'd0);
    issue(2'b00, 5'd2, 32'h77);
    tick(); in_valid = 1'b0;
    chk("post_rst_acc_wen", {31'd0, wen}, 32'd1);
    chk("post_rst_acc_wdata", wdata, 32'h77);
    tick();
    chk("post_rst_acc_cnt", retire_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_25060170_wbu.md
YSYX_25060170_WBU -- requirements
Module: ysyx_25060170_WBU

Interface
REQ-001 SHALL have parameter: W, 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  WBU accepts upstream this cycle.
- in_pc  input  32  instruction PC.
- in_rd  input  5  destination register.
- in_rd_wen  input  1  instruction writes rd.
- in_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR.
- in_alu  input  32  ALU result.
- in_ld_data  input  32  raw aligned load word.
- in_ld_addr_lo  input  2  load address bits [1:0].
- in_ld_funct3  input  3  load type.
- in_csr_rdata  input  32  CSR read value.
- gpr_ready  input  1  register file ready (its ready_o).
- wdata  output  32  GPR write data.
- waddr  output  5  GPR write address.
- wen  output  1  GPR write enable.
- commit_valid  output  1  instruction retires this cycle.
- commit_pc  output  32  PC of retiring instruction.
- retire_cnt  output  32  retired-instruction count.

Function
REQ-003 SHALL hold one writeback entry (wb_valid, pc, rd, rd_wen, result).
REQ-004 SHALL drive in_ready = !wb_valid || gpr_ready (combinational).
REQ-005 SHALL accept on in_valid && in_ready: compute result, load entry, set wb_valid at that edge; one-cycle latency from accept to wen.
REQ-006 SHALL retire on wb_valid && gpr_ready: commit_valid=1, commit_pc=entry pc; wb_valid clears at that edge unless a new accept occurs in the same cycle, in which case the entry reloads with no bubble.
REQ-007 SHALL drive wen = wb_valid && gpr_ready && rd_wen && (rd != 0); waddr = entry rd; wdata = entry result.
REQ-008 SHALL compute result by in_sel: 00 in_alu; 01 load-extended data; 10 in_pc+4, mod 2^32; 11 in_csr_rdata.
REQ-009 SHALL extend loads as follows; byte lane = in_ld_addr_lo, half lane = in_ld_addr_lo[1], addr_lo[0] ignored for halves:
- 000 LB: sign-extend byte.
- 001 LH: sign-extend half.
- 010 LW: full word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend half.
- other funct3: full raw word.
REQ-010 SHALL increment retire_cnt by 1 per retire, wrapping 0xFFFFFFFF -> 0.
REQ-011 SHALL hold entry and outputs stable while wb_valid && !gpr_ready.
REQ-012 SHALL, with rd == 0 or rd_wen == 0, still retire (commit_valid, count) with wen = 0.
REQ-013 SHALL ignore upstream inputs when in_valid == 0.

Reset
REQ-014 SHALL, on rst low, asynchronously clear: wb_valid=0, retire_cnt=0, entry pc/rd/result=0, rd_wen=0.
REQ-015 SHALL force wen=0 and commit_valid=0, with wdata/waddr/commit_pc=0, while in reset; in_ready=1 once wb_valid=0.
REQ-016 SHALL drop an in-flight entry on reset mid-operation: no write, no retire count.
REQ-017 SHALL begin accepting on the first rising edge after rst deasserts.

Verification
REQ-018 ALU path: in_sel=00, in_alu=0x12345678, in_rd=5, rd_wen=1, gpr_ready=1 -> next cycle wen=1, waddr=5, wdata=0x12345678, commit_valid=1, retire_cnt=1.
REQ-019 Loads: in_ld_data=0x80FF7F01:
- LB, addr_lo=2 -> 0xFFFFFFFF.
- LBU, addr_lo=3 -> 0x00000080.
- LH, addr_lo=0 -> 0x00007F01.
- LHU, addr_lo=2 -> 0x000080FF.
REQ-020 Backpressure: gpr_ready=0 for 3 cycles with entry held -> in_ready=0, wen=0, outputs stable; gpr_ready=1 -> exactly one write and one retire.
REQ-021 Back-to-back: 4 instructions, in_valid and gpr_ready constant 1 -> 4 consecutive writes, no bubbles, retire_cnt=4.
REQ-022 x0 and JAL: in_rd=0, in_sel=10, in_pc=0xFFFFFFFC -> wen=0, commit_valid=1; same with rd=1 -> wdata=0x00000000.
REQ-023 Reset mid-op: entry valid, gpr_ready=0, rst low -> wen=0 immediately, retire_cnt=0, in_ready=1; no write after release.
